// File: rtl/agc_timer_pkg.sv
// Shared constants and types for the AGC master timing generator.
// The optional stop/HALT feature is selected by the AGC_TIMER_STOP_EN macro.
package agc_timer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        P4   = 3'd4,
        HALT = 3'd5
    } phase_e;

    localparam int TP_W = 4;
    typedef logic [TP_W-1:0] tp_t;

    localparam tp_t    TP_COUNT  = tp_t'(12);
    localparam tp_t    OVF_TP    = tp_t'(12);
    localparam phase_e OVF_PHASE = P2;

    // Next time-pulse number, wrapping TP_COUNT back to 1.
    function automatic tp_t nextTp(input tp_t tp);
        return (tp == TP_COUNT) ? tp_t'(1) : tp + tp_t'(1);
    endfunction

endpackage

// File: rtl/agc_timer_if.sv
// Strobe bundle of the AGC timer: the timer drives the phase strobes and
// accepts the stop request; consumers use the slave view.
interface agc_timer_if;
    logic stop;
    logic rt;
    logic phs2;
    logic phs2_n;
    logic wt;
    logic wt_n;
    logic phs4;
    logic phs4_n;
    logic ct;
    logic ct_n;
    logic ovfstb_n;

    modport master (
        input  stop,
        output rt, phs2, phs2_n, wt, wt_n, phs4, phs4_n, ct, ct_n, ovfstb_n
    );

    modport slave (
        output stop,
        input  rt, phs2, phs2_n, wt, wt_n, phs4, phs4_n, ct, ct_n, ovfstb_n
    );
endinterface

// File: rtl/agc_timer_tp_counter.sv
// Time-pulse counter running 1..TP_COUNT; synchronous reset/load to 1,
// hold overrides advance.
module agc_timer_tp_counter
    import agc_timer_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic advance_i,
    input  logic hold_i,
    output tp_t  tp_o
);

    tp_t tp_q;
    tp_t tp_d;

    always_comb begin
        tp_d = tp_q;
        if (load_i) begin
            tp_d = tp_t'(1);
        end else if (!hold_i && advance_i) begin
            tp_d = nextTp(tp_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tp_q <= tp_t'(1);
        end else begin
            tp_q <= tp_d;
        end
    end

    assign tp_o = tp_q;

endmodule

// File: rtl/agc_timer.sv
// AGC master timing generator: four-phase sequencer with 12 time pulses per
// memory cycle. Define AGC_TIMER_STOP_EN to build the stop/HALT feature.
module agc_timer
    import agc_timer_pkg::*;
(
    input  logic          clock,
    input  logic          rst,
    input  logic          vcc,
    input  logic          gnd,
    agc_timer_if.master   bus
);

    phase_e state_q;
    phase_e state_d;
    logic   tpLoad;
    logic   tpAdvance;
    logic   tpHold;
    tp_t    tp;

`ifdef AGC_TIMER_STOP_EN
    logic unused_ties;
    assign unused_ties = ^{vcc, gnd};
`else
    logic unused_ties;
    assign unused_ties = ^{vcc, gnd, bus.stop};
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop is only looked at in P4 and HALT, so a halt always lands on a
    // time-pulse boundary and tp holds until the sequence resumes.
    always_comb begin
        state_d   = state_q;
        tpLoad    = 1'b0;
        tpAdvance = 1'b0;
        tpHold    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = P1;
                tpLoad  = 1'b1;
            end
            P1: state_d = P2;
            P2: state_d = P3;
            P3: state_d = P4;
`ifdef AGC_TIMER_STOP_EN
            P4: begin
                if (bus.stop) begin
                    state_d = HALT;
                    tpHold  = 1'b1;
                end else begin
                    state_d   = P1;
                    tpAdvance = 1'b1;
                end
            end
            HALT: begin
                if (bus.stop) begin
                    tpHold = 1'b1;
                end else begin
                    state_d   = P1;
                    tpAdvance = 1'b1;
                end
            end
`else
            P4: begin
                state_d   = P1;
                tpAdvance = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    agc_timer_tp_counter u_tp_counter (
        .clk_i     (clock),
        .rst_i     (rst),
        .load_i    (tpLoad),
        .advance_i (tpAdvance),
        .hold_i    (tpHold),
        .tp_o      (tp)
    );

    assign bus.rt       = (state_q == P1);
    assign bus.phs2     = (state_q == P2);
    assign bus.wt       = (state_q == P3);
    assign bus.phs4     = (state_q == P4);
    assign bus.ct       = (state_q == P4);
    assign bus.phs2_n   = ~bus.phs2;
    assign bus.wt_n     = ~bus.wt;
    assign bus.phs4_n   = ~bus.phs4;
    assign bus.ct_n     = ~bus.ct;
    assign bus.ovfstb_n = ~((state_q == OVF_PHASE) && (tp == OVF_TP));

endmodule

// File: tb/tb_agc_timer.sv
// Bench for agc_timer: directed scenarios plus random stop/reset traffic,
// checked against a running-clock-count model of the sequencer.
module tb_agc_timer;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   logic vcc   = 1'b1;
   logic gnd   = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   // Model: number of running clocks since P1/T01, plus idle/halt flags.
   bit mIdle   = 1'b1;
   bit mHalted = 1'b0;
   int mCnt    = 0;

   agc_timer_if bus ();

   agc_timer dut (
      .clock (clock),
      .rst   (rst),
      .vcc   (vcc),
      .gnd   (gnd),
      .bus   (bus)
   );

   always #5 clock = ~clock;

`ifdef AGC_TIMER_STOP_EN
   localparam bit STOP_EN = 1'b1;
`else
   localparam bit STOP_EN = 1'b0;
`endif

   function automatic int modelPhase();
      return mCnt % 4;
   endfunction

   function automatic int modelTp();
      return (mCnt / 4) % 12 + 1;
   endfunction

   // Advance the model by one clock edge given the inputs seen at that edge.
   task automatic updateModel(input bit rstv, input bit stopv);
      if (rstv) begin
         mIdle = 1'b1; mHalted = 1'b0; mCnt = 0;
      end else if (mIdle) begin
         mIdle = 1'b0; mCnt = 0;
      end else if (mHalted) begin
         if (!stopv) begin
            mHalted = 1'b0; mCnt = mCnt + 1;
         end
      end else if (STOP_EN && stopv && modelPhase() == 3) begin
         mHalted = 1'b1;
      end else begin
         mCnt = mCnt + 1;
      end
   endtask

   // Expected {rt,phs2,wt,phs4,ct,phs2_n,phs4_n,wt_n,ct_n,ovfstb_n}.
   function automatic logic [9:0] expectedOutputs();
      bit run;
      logic rtE, p2E, wtE, p4E, ovfE;
      run  = !mIdle && !mHalted;
      rtE  = run && modelPhase() == 0;
      p2E  = run && modelPhase() == 1;
      wtE  = run && modelPhase() == 2;
      p4E  = run && modelPhase() == 3;
      ovfE = !(p2E && modelTp() == 12);
      return {rtE, p2E, wtE, p4E, p4E, ~p2E, ~p4E, ~wtE, ~p4E, ovfE};
   endfunction

   task automatic checkOutput(input string tag);
      logic [9:0] observed;
      logic [9:0] expected;
      observed = {bus.rt, bus.phs2, bus.wt, bus.phs4, bus.ct,
                  bus.phs2_n, bus.phs4_n, bus.wt_n, bus.ct_n, bus.ovfstb_n};
      expected = expectedOutputs();
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %b expected %b (tp %0d phase %0d)",
                tag, observed, expected, modelTp(), modelPhase());
      end
   endtask

   task automatic applyStimulus(input bit rstv, input bit stopv, input string tag);
      rst      = rstv;
      bus.stop = stopv;
      @(posedge clock);
      #1;
      updateModel(rstv, stopv);
      checkOutput(tag);
   endtask

   task automatic runUntil(input int tp, input int ph, input string tag);
      int budget = 60;
      while (!(!mIdle && !mHalted && modelTp() == tp && modelPhase() == ph) && budget > 0) begin
         applyStimulus(1'b0, 1'b0, tag);
         budget--;
      end
      if (budget == 0) begin
         miscompares++;
         $display("[TB] FAIL %s: target T%0d phase %0d not reached, got T%0d phase %0d",
                  tag, tp, ph, modelTp(), modelPhase());
      end
   endtask

   initial begin
      bus.stop = 1'b0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "reset_hold");

      for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, "free_run");

      runUntil(5, 1, "seek_T05_P2");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, "stop_hold");
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, "stop_resume");

      runUntil(7, 2, "seek_T07_P3");
      applyStimulus(1'b1, 1'b0, "mid_reset");
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, "mid_reset_restart");

`ifdef AGC_TIMER_STOP_EN
      for (int i = 0; i < 8 && !mHalted; i++) applyStimulus(1'b0, 1'b1, "seek_halt");
      if (!mHalted) begin
         miscompares++;
         $display("[TB] FAIL seek_halt: model never reached HALT");
      end
`else
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, "stop_ignored");
`endif
      applyStimulus(1'b1, 1'b1, "reset_in_halt");
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, "halt_reset_restart");

      for (int i = 0; i < 400; i++) begin
         vcc = 1'($urandom);
         gnd = 1'($urandom);
         applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0), "random");
      end
      vcc = 1'b1;
      gnd = 1'b0;

      applyStimulus(1'b1, 1'b0, "reset_before_stopheld");
      for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, "stop_held");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
